// File: rtl/cp0_regfile.sv
// cp0_regfile: Coprocessor-0 register file and exception sequencer (MEM stage).
//
// Holds Status(12), Cause(13), EPC(14) and the constant PrId(15). It executes
// MFC0/MTC0/SYSCALL/ERET and hardware-interrupt entry for the instruction in
// MEM, and drives the pipeline flush and redirect target combinationally.
//
// Ports:
//   clk, rst_n      rising-edge clock, asynchronous active-low reset
//   mem_valid       MEM stage holds a real instruction
//   mem_cp0Op       000 none, 001 MFC0, 010 MTC0, 011 SYSCALL, 100 ERET
//   mem_cp0Rd       CP0 register number
//   mem_wdata       MTC0 write data (rt)
//   mem_pc          PC of the MEM instruction
//   hwInt           asynchronous interrupt lines (synchronised internally)
//   mem_cp0Rdata    MFC0 read data (combinational mux of current registers)
//   exc_flush       flush IF/ID/EX/MEM and load exc_pc at the next edge
//   exc_pc          redirect target
//   status/cause/epc  current register values
module cp0_regfile #(
  parameter logic [31:0] EXC_VECTOR = 32'h0000_4180,
  parameter logic [31:0] PRID       = 32'h0001_8000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_valid,
  input  logic [2:0]  mem_cp0Op,
  input  logic [4:0]  mem_cp0Rd,
  input  logic [31:0] mem_wdata,
  input  logic [31:0] mem_pc,
  input  logic [5:0]  hwInt,
  output logic [31:0] mem_cp0Rdata,
  output logic        exc_flush,
  output logic [31:0] exc_pc,
  output logic [31:0] status,
  output logic [31:0] cause,
  output logic [31:0] epc
);

  typedef enum logic [2:0] {
    OP_NONE    = 3'b000,
    OP_MFC0    = 3'b001,
    OP_MTC0    = 3'b010,
    OP_SYSCALL = 3'b011,
    OP_ERET    = 3'b100
  } cp0_op_e;

  localparam logic [4:0] EXC_INT = 5'd0;
  localparam logic [4:0] EXC_SYS = 5'd8;

  cp0_op_e     op;
  logic [5:0]  im;
  logic        exl;
  logic        ie;
  logic [4:0]  exc_code;
  logic [31:0] epc_q;
  logic [5:0]  hw_sync1;
  logic [5:0]  ip;
  logic        int_req;
  logic        take_int;
  logic        take_sys;
  logic        take_eret;
  logic        take_mtc0;

  assign op = cp0_op_e'(mem_cp0Op);

  assign status = {16'h0000, im, 8'h00, exl, ie};
  assign cause  = {16'h0000, ip, 3'b000, exc_code, 2'b00};
  assign epc    = epc_q;

  assign int_req = ie & ~exl & (|(im & ip));

  // Interrupt outranks every op; the remaining ops are mutually exclusive by
  // opcode, so each take_* only needs to exclude the interrupt.
  always_comb begin
    take_int  = 1'b0;
    take_sys  = 1'b0;
    take_eret = 1'b0;
    take_mtc0 = 1'b0;
    if (mem_valid) begin
      if (int_req) begin
        take_int = 1'b1;
      end else begin
        unique case (op)
          OP_SYSCALL: take_sys  = 1'b1;
          OP_ERET:    take_eret = 1'b1;
          OP_MTC0:    take_mtc0 = 1'b1;
          default:    ;
        endcase
      end
    end
  end

  always_comb begin
    exc_flush = rst_n & (take_int | take_sys | take_eret);
    exc_pc    = EXC_VECTOR;
    if (rst_n && take_eret) begin
      exc_pc = epc_q;
    end
  end

  always_comb begin
    mem_cp0Rdata = '0;
    unique case (mem_cp0Rd)
      5'd12:   mem_cp0Rdata = status;
      5'd13:   mem_cp0Rdata = cause;
      5'd14:   mem_cp0Rdata = epc_q;
      5'd15:   mem_cp0Rdata = PRID;
      default: mem_cp0Rdata = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hw_sync1 <= '0;
      ip       <= '0;
    end else begin
      hw_sync1 <= hwInt;
      ip       <= hw_sync1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      im       <= '0;
      exl      <= 1'b0;
      ie       <= 1'b0;
      exc_code <= '0;
      epc_q    <= '0;
    end else if (take_int) begin
      epc_q    <= {mem_pc[31:2], 2'b00};
      exc_code <= EXC_INT;
      exl      <= 1'b1;
    end else if (take_sys) begin
      epc_q    <= {mem_pc[31:2] + 30'd1, 2'b00};
      exc_code <= EXC_SYS;
      exl      <= 1'b1;
    end else if (take_eret) begin
      exl <= 1'b0;
    end else if (take_mtc0) begin
      unique case (mem_cp0Rd)
        5'd12: begin
          im  <= mem_wdata[15:10];
          exl <= mem_wdata[1];
          ie  <= mem_wdata[0];
        end
        5'd14:   epc_q <= {mem_wdata[31:2], 2'b00};
        default: ;
      endcase
    end
  end

endmodule
